// File: rtl/ew_fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO: push request, synchronised read pointer in;
// RAM strobe/address, Gray write pointer, fill level and flags out.
interface ew_fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [ADDR_WIDTH:0]   rd_ptr_gray_s;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH:0]   wr_ptr_gray;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;

    modport master (
        output wr_en, rd_ptr_gray_s,
        input  ram_we, wr_addr, wr_ptr_gray, wr_count, full, almost_full, overflow
    );

    modport slave (
        input  wr_en, rd_ptr_gray_s,
        output ram_we, wr_addr, wr_ptr_gray, wr_count, full, almost_full, overflow
    );
endinterface

// File: rtl/ew_fifo_wr_ctrl.sv
// Async FIFO write-domain controller: owns write pointer, RAM strobe, Gray pointer and fill flags.
// Latency: ram_we combinational with wr_en; pointer/count/flags registered, visible one edge later.
// Backpressure: pushes are dropped while full is high (flagged by overflow); init_n low blocks pushes.
module ew_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2,
    parameter int ERR_MODE   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init_n,
    ew_fifo_wr_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_THR = DEPTH - PW'(AF_LEVEL);

    logic [ADDR_WIDTH:0]   wbin_q, wbin_d;
    logic [ADDR_WIDTH:0]   gray_q, gray_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  af_q, af_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_WIDTH:0]   rbin;
    logic                  acc;
    logic                  ovf_ev;

    // Bit i of the binary read pointer is the XOR of Gray bits MSB..i.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            rbin[i] = ^(bus.rd_ptr_gray_s >> i);
        end
    end

    always_comb begin
        // rst_n gating keeps the RAM strobe quiet while the pointer is held in reset.
        acc    = bus.wr_en & ~full_q & init_n & rst_n;
        ovf_ev = bus.wr_en & full_q & init_n;
        wbin_d = wbin_q + PW'(acc);
        gray_d = wbin_d ^ (wbin_d >> 1);
        addr_d = wbin_d[ADDR_WIDTH-1:0];
        cnt_d  = wbin_d - rbin;
        full_d = (cnt_d == DEPTH);
        af_d   = (cnt_d >= AF_THR);
        ovf_d  = (ERR_MODE == 0) ? (ovf_q | ovf_ev) : ovf_ev;
        if (!init_n) begin
            wbin_d = '0;
            gray_d = '0;
            addr_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
            af_d   = 1'b0;
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q <= '0;
            gray_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wbin_q <= wbin_d;
            gray_q <= gray_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.ram_we      = acc;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_ptr_gray = gray_q;
    assign bus.wr_count    = cnt_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_ew_fifo_wr_ctrl.sv
// Randomised bench for ew_fifo_wr_ctrl: sticky (ERR_MODE 0) and pulse (ERR_MODE 1) instances
// share stimulus and are checked against a word-counting model of the FIFO.
module tb_ew_fifo_wr_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic init_n;

    always #5 clk = ~clk;

    ew_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) b0 ();
    ew_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) b1 ();

    ew_fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(2), .ERR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .bus(b0)
    );
    ew_fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(2), .ERR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .bus(b1)
    );

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Model: words ever pushed since last clear, and words the reader has consumed.
    int       pushed;
    int       rd;
    int       m_cnt;
    bit       m_full, m_af, m_ovf0, m_ovf1;
    logic [4:0] prev_gray;
    int       wraps = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic check_regs();
        chk("addr0",  b0.wr_addr,     pushed % 16);
        chk("gray0",  b0.wr_ptr_gray, gray5(pushed % 32));
        chk("cnt0",   b0.wr_count,    m_cnt);
        chk("full0",  b0.full,        m_full);
        chk("af0",    b0.almost_full, m_af);
        chk("ovf0",   b0.overflow,    m_ovf0);
        chk("addr1",  b1.wr_addr,     pushed % 16);
        chk("gray1",  b1.wr_ptr_gray, gray5(pushed % 32));
        chk("cnt1",   b1.wr_count,    m_cnt);
        chk("full1",  b1.full,        m_full);
        chk("af1",    b1.almost_full, m_af);
        chk("ovf1",   b1.overflow,    m_ovf1);
        chk("ham",    ($countones(b0.wr_ptr_gray ^ prev_gray) <= 1), 1);
        if (prev_gray == 5'b10000 && b0.wr_ptr_gray == 5'b00000) wraps++;
        prev_gray = b0.wr_ptr_gray;
    endtask

    task automatic drive(input bit wr, input bit ini, input int rd_new);
        b0.wr_en = wr;
        b1.wr_en = wr;
        init_n   = ini;
        rd       = rd_new;
        b0.rd_ptr_gray_s = gray5(rd % 32);
        b1.rd_ptr_gray_s = gray5(rd % 32);
    endtask

    // Called just after a falling edge; drives inputs, checks ram_we, then the registered result.
    task automatic cycle(input bit wr, input bit ini, input int rd_new);
        bit exp_we, ev;
        drive(wr, ini, rd_new);
        #1;
        exp_we = wr && ini && !m_full;
        chk("ram_we0", b0.ram_we, exp_we);
        chk("ram_we1", b1.ram_we, exp_we);
        @(posedge clk);
        ev = wr && ini && m_full;
        if (!ini) begin
            pushed = 0;
            m_ovf0 = 0;
            m_ovf1 = 0;
            m_cnt  = 0;
            prev_gray = 5'b0;
        end else begin
            if (exp_we) pushed++;
            m_ovf0 = m_ovf0 | ev;
            m_ovf1 = ev;
            m_cnt  = pushed - rd;
        end
        m_full = (m_cnt == 16);
        m_af   = (m_cnt >= 14);
        @(negedge clk);
        check_regs();
    endtask

    // Asserts rst_n at an arbitrary moment, checks the immediate clear, releases at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 0);
        pushed = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf0 = 0; m_ovf1 = 0;
        prev_gray = 5'b0;
        #1;
        chk("rst_we0", b0.ram_we, 0);
        chk("rst_we1", b1.ram_we, 0);
        chk("rst_cnt", b0.wr_count, 0);
        chk("rst_ptr", b0.wr_ptr_gray, 0);
        repeat (2) @(negedge clk);
        check_regs();
        chk("rst_we_hold", b0.ram_we, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rn;
        bit wr, ini;
        rst_n  = 1'b1;
        init_n = 1'b1;
        drive(1'b0, 1'b1, 0);
        #2;
        phase = "reset";
        do_reset();

        phase = "first";
        cycle(1, 1, 0);
        chk("first_addr", b0.wr_addr, 1);
        chk("first_gray", b0.wr_ptr_gray, 5'b00001);

        phase = "fill";
        repeat (15) cycle(1, 1, 0);
        chk("fill_full", b0.full, 1);
        chk("fill_gray", b0.wr_ptr_gray, 5'b11000);

        phase = "overflow";
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        phase = "release";
        cycle(0, 1, 4);
        chk("rel_cnt", b0.wr_count, 12);

        phase = "init_clr";
        cycle(0, 0, 0);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom_range(0, 3) != 0);
            ini = ($urandom_range(0, 199) != 0);
            rn  = rd;
            if (rd < pushed && $urandom_range(0, 9) < 7) begin
                rn = rd + 1;
                if (rn < pushed && $urandom_range(0, 3) == 0) rn = rn + 1;
            end
            if (!ini) rn = 0;
            cycle(wr, ini, rn);
        end
        chk("wrap_seen", (wraps > 0), 1);

        phase = "init_mid";
        cycle(0, 0, 0);
        repeat (7) cycle(1, 1, 0);
        chk("pre_init_cnt", b0.wr_count, 7);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        chk("post_init_addr", b0.wr_addr, 1);

        phase = "async_rst";
        repeat (3) cycle(1, 1, 0);
        @(posedge clk);
        #2;
        do_reset();
        cycle(1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
